mbc1_bank_ctrl: RTL and testbench

Parametrised cartridge memory bank controller that replaces the fixed-mapping pass-through. It selects between the CPU and DMA address buses and captures MBC1 control-register writes. It also translates 16-bit bus addresses into physical ROM and external RAM addresses. It sits between the bus arbiter and the cartridge ROM/RAM memories. MBC_TYPE=0 keeps the legacy ROM-only behaviour.

---
 rtl/mbc1_bank_ctrl.sv | 92 +++++++++
 tb/tb_mbc1_bank_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mbc1_bank_ctrl.sv
// ============================================================================
// Module   : mbc1_bank_ctrl
// Brief    : Cartridge bank controller. Selects the CPU or DMA bus address,
//            captures MBC1 control writes and maps ROM/external RAM addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbc1_bank_ctrl #(
  parameter int MBC_TYPE      = 1,
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [15:0]                address_bus_offset,
  input  logic [15:0]                address_bus_dma_rd,
  input  logic                       dma_sel_cart_rom,
  input  logic [7:0]                 data_bus_in,
  input  logic                       cart_wr,
  output logic [15:0]                address_bus_out,
  output logic [ROM_BANK_BITS+13:0]  rom_address,
  output logic [RAM_BANK_BITS+12:0]  ext_ram_address,
  output logic                       ext_ram_cs,
  output logic [1:0]                 ext_ram_bank_sel
);

  localparam logic [4:0] c_bank_lo_rst = 5'd1;

  logic                     r_cart_wr_d;
  logic                     r_ram_en;
  logic [4:0]               r_bank_lo;
  logic [1:0]               r_bank_hi;
  logic                     r_mode;

  logic                     w_wr_event;
  logic [15:0]              w_sel_addr;
  logic [6:0]               w_bank_full;
  logic [RAM_BANK_BITS-1:0] w_ram_bank;
  logic                     w_ram_gate;
  logic                     w_unused;

  assign w_sel_addr      = dma_sel_cart_rom ? address_bus_dma_rd : address_bus_offset;
  assign address_bus_out = w_sel_addr;

  // Rising edge of the strobe: one register update per assertion.
  assign w_wr_event = cart_wr & ~r_cart_wr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cart_wr_d <= 1'b0;
      r_ram_en    <= 1'b0;
      r_bank_lo   <= c_bank_lo_rst;
      r_bank_hi   <= 2'd0;
      r_mode      <= 1'b0;
    end else begin
      r_cart_wr_d <= cart_wr;
      if ((MBC_TYPE != 0) && w_wr_event && !address_bus_offset[15]) begin
        case (address_bus_offset[14:13])
          2'd0: r_ram_en  <= (data_bus_in[3:0] == 4'hA);
          2'd1: r_bank_lo <= (data_bus_in[4:0] == 5'd0) ? 5'd1 : data_bus_in[4:0];
          2'd2: r_bank_hi <= data_bus_in[1:0];
          default: r_mode <= data_bus_in[0];
        endcase
      end
    end
  end

  generate
    if (MBC_TYPE == 0) begin : g_rom_only
      assign w_bank_full = {6'd0, w_sel_addr[14]};
      assign w_ram_gate  = 1'b1;
    end else begin : g_mbc1
      assign w_bank_full = w_sel_addr[14] ? {r_bank_hi, r_bank_lo}
                         : (r_mode ? {r_bank_hi, 5'd0} : 7'd0);
      assign w_ram_gate  = r_ram_en;
    end
  endgenerate

  // Truncating the bank index makes oversized bank numbers wrap.
  assign rom_address = {w_bank_full[ROM_BANK_BITS-1:0], w_sel_addr[13:0]};

  assign w_ram_bank       = r_mode ? r_bank_hi[RAM_BANK_BITS-1:0] : '0;
  assign ext_ram_address  = {w_ram_bank, w_sel_addr[12:0]};
  assign ext_ram_bank_sel = 2'(w_ram_bank);
  assign ext_ram_cs       = (w_sel_addr[15:13] == 3'b101) & w_ram_gate;

  assign w_unused = ^{data_bus_in[7:5], w_bank_full, r_bank_hi};

endmodule

`default_nettype wire

// File: tb/tb_mbc1_bank_ctrl.sv
// ============================================================================
// Module   : tb_mbc1_bank_ctrl
// Brief    : Directed self-checking bench for mbc1_bank_ctrl (MBC1, narrow ROM
//            and ROM-only instances driven from the same buses).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbc1_bank_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address_bus_offset;
  logic [15:0] address_bus_dma_rd;
  logic        dma_sel_cart_rom;
  logic [7:0]  data_bus_in;
  logic        cart_wr;

  logic [15:0] m1_addr_out, m5_addr_out, m0_addr_out;
  logic [20:0] m1_rom;
  logic [18:0] m5_rom;
  logic [20:0] m0_rom;
  logic [14:0] m1_ram;
  logic [13:0] m5_ram;
  logic [14:0] m0_ram;
  logic        m1_cs, m5_cs, m0_cs;
  logic [1:0]  m1_sel, m5_sel, m0_sel;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mbc1_bank_ctrl #(.MBC_TYPE(1), .ROM_BANK_BITS(7), .RAM_BANK_BITS(2)) u_mbc1 (
    .clock(clock), .reset(reset),
    .address_bus_offset(address_bus_offset), .address_bus_dma_rd(address_bus_dma_rd),
    .dma_sel_cart_rom(dma_sel_cart_rom), .data_bus_in(data_bus_in), .cart_wr(cart_wr),
    .address_bus_out(m1_addr_out), .rom_address(m1_rom), .ext_ram_address(m1_ram),
    .ext_ram_cs(m1_cs), .ext_ram_bank_sel(m1_sel)
  );

  mbc1_bank_ctrl #(.MBC_TYPE(1), .ROM_BANK_BITS(5), .RAM_BANK_BITS(1)) u_mbc1_small (
    .clock(clock), .reset(reset),
    .address_bus_offset(address_bus_offset), .address_bus_dma_rd(address_bus_dma_rd),
    .dma_sel_cart_rom(dma_sel_cart_rom), .data_bus_in(data_bus_in), .cart_wr(cart_wr),
    .address_bus_out(m5_addr_out), .rom_address(m5_rom), .ext_ram_address(m5_ram),
    .ext_ram_cs(m5_cs), .ext_ram_bank_sel(m5_sel)
  );

  mbc1_bank_ctrl #(.MBC_TYPE(0), .ROM_BANK_BITS(7), .RAM_BANK_BITS(2)) u_rom_only (
    .clock(clock), .reset(reset),
    .address_bus_offset(address_bus_offset), .address_bus_dma_rd(address_bus_dma_rd),
    .dma_sel_cart_rom(dma_sel_cart_rom), .data_bus_in(data_bus_in), .cart_wr(cart_wr),
    .address_bus_out(m0_addr_out), .rom_address(m0_rom), .ext_ram_address(m0_ram),
    .ext_ram_cs(m0_cs), .ext_ram_bank_sel(m0_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; the leading edge wait lets cart_wr_d clear between writes.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clock); #1;
    dma_sel_cart_rom   = 1'b0;
    address_bus_offset = addr;
    data_bus_in        = data;
    cart_wr            = 1'b1;
    @(posedge clock); #1;
    cart_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr);
    dma_sel_cart_rom   = 1'b0;
    address_bus_offset = addr;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    address_bus_offset = 16'h0000;
    address_bus_dma_rd = 16'h0000;
    dma_sel_cart_rom   = 1'b0;
    data_bus_in        = 8'h00;
    cart_wr            = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    cpu_read(16'h4123);
    check_eq("rst_rom_4123", 32'(m1_rom), 32'h04123);
    check_eq("rst_addr_out", 32'(m1_addr_out), 32'h4123);
    cpu_read(16'h0123);
    check_eq("rst_rom_0123", 32'(m1_rom), 32'h00123);
    cpu_read(16'hA000);
    check_eq("rst_ram_cs", 32'(m1_cs), 32'h0);
    check_eq("rst_ram_sel", 32'(m1_sel), 32'h0);
    check_eq("rom_only_cs", 32'(m0_cs), 32'h1);

    // Bank 0 written maps to bank 1; max low bank
    cpu_write(16'h2000, 8'h00);
    cpu_read(16'h4000);
    check_eq("bank0_as_1", 32'(m1_rom), 32'h04000);
    cpu_write(16'h2000, 8'h1F);
    cpu_read(16'h7FFF);
    check_eq("bank_1f", 32'(m1_rom), 32'h7FFFF);

    // RAM enable, upper bank bits, mode 1
    cpu_write(16'h0000, 8'h0A);
    cpu_write(16'h4000, 8'h02);
    cpu_write(16'h6000, 8'h01);
    cpu_read(16'hA010);
    check_eq("ram_cs_en", 32'(m1_cs), 32'h1);
    check_eq("ram_sel_2", 32'(m1_sel), 32'h2);
    check_eq("ram_addr", 32'(m1_ram), 32'h4010);
    check_eq("small_ram_addr", 32'(m5_ram), 32'h0010);
    check_eq("small_ram_sel", 32'(m5_sel), 32'h0);
    cpu_read(16'h0000);
    check_eq("mode1_bank0", 32'(m1_rom), 32'h100000);
    check_eq("small_bank0_wrap", 32'(m5_rom), 32'h0);
    cpu_read(16'h4000);
    check_eq("bank_5f", 32'(m1_rom), 32'h17C000);
    check_eq("small_bank_wrap", 32'(m5_rom), 32'h7C000);
    cpu_write(16'h6000, 8'h00);
    cpu_read(16'hA010);
    check_eq("mode0_ram_sel", 32'(m1_sel), 32'h0);
    check_eq("mode0_ram_addr", 32'(m1_ram), 32'h0010);
    check_eq("mode0_ram_cs", 32'(m1_cs), 32'h1);
    cpu_write(16'h0000, 8'h0B);
    cpu_read(16'hA010);
    check_eq("ram_disable", 32'(m1_cs), 32'h0);

    // Held strobe: only the first cycle's data is captured
    @(posedge clock); #1;
    address_bus_offset = 16'h2000;
    data_bus_in        = 8'h03;
    cart_wr            = 1'b1;
    @(posedge clock); #1;
    data_bus_in = 8'h05;
    repeat (3) @(posedge clock);
    #1 cart_wr = 1'b0;
    cpu_read(16'h4000);
    check_eq("held_strobe", 32'(m1_rom), 32'h10C000);

    // Writes above 0x7FFF are ignored
    cpu_write(16'hA000, 8'h1E);
    cpu_read(16'h4000);
    check_eq("high_write_ign", 32'(m1_rom), 32'h10C000);

    // DMA path with bank 4
    cpu_write(16'h4000, 8'h00);
    cpu_write(16'h2000, 8'h04);
    @(posedge clock); #1;
    dma_sel_cart_rom   = 1'b1;
    address_bus_dma_rd = 16'h5000;
    address_bus_offset = 16'hFF80;
    @(negedge clock);
    check_eq("dma_addr_out", 32'(m1_addr_out), 32'h5000);
    check_eq("dma_rom", 32'(m1_rom), 32'h11000);

    // Write concurrent with DMA read: DMA sees pre-write bank first
    @(posedge clock); #1;
    address_bus_offset = 16'h2000;
    data_bus_in        = 8'h07;
    cart_wr            = 1'b1;
    @(negedge clock);
    check_eq("dma_prewrite", 32'(m1_rom), 32'h11000);
    @(posedge clock); #1;
    cart_wr = 1'b0;
    @(negedge clock);
    check_eq("dma_postwrite", 32'(m1_rom), 32'h1D000);

    // Reset with strobe held, then a new capture after release
    @(posedge clock); #1;
    address_bus_dma_rd = 16'h4000;
    address_bus_offset = 16'h2000;
    data_bus_in        = 8'h06;
    cart_wr            = 1'b1;
    @(posedge clock); #1;
    check_eq("pre_reset_bank6", 32'(m1_rom), 32'h18000);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("reset_held_rom", 32'(m1_rom), 32'h04000);
    data_bus_in = 8'h02;
    reset       = 1'b0;
    @(posedge clock); #1;
    check_eq("post_reset_capture", 32'(m1_rom), 32'h08000);
    data_bus_in = 8'h03;
    @(posedge clock); #1;
    check_eq("post_reset_single", 32'(m1_rom), 32'h08000);
    cart_wr = 1'b0;

    // ROM-only ignores bank writes
    cpu_write(16'h2000, 8'h05);
    cpu_read(16'h4000);
    check_eq("rom_only_4000", 32'(m0_rom), 32'h04000);
    check_eq("mbc1_bank5", 32'(m1_rom), 32'h14000);
    cpu_read(16'h0123);
    check_eq("rom_only_0123", 32'(m0_rom), 32'h00123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
